// File: rtl/vga_text_console_writer.sv
// Text console writer for an 80x30 VGA character buffer.
// Turns a character stream, clear and colour events into Avalon-MM writes.
module vga_text_console_writer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CHAR_VALID,
  input  logic [7:0]  CHAR_DATA,
  output logic        CHAR_READY,
  input  logic        CLEAR_REQ,
  input  logic        COLOR_WE,
  input  logic [31:0] COLOR_DATA,
  output logic [11:0] M_ADDR,
  output logic        M_WRITE,
  output logic [3:0]  M_BYTE_EN,
  output logic [31:0] M_WRITEDATA,
  input  logic        M_WAITREQUEST,
  output logic [6:0]  CURSOR_X,
  output logic [4:0]  CURSOR_Y,
  output logic        BUSY
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WR_CHAR = 2'd1;
  localparam logic [1:0] CLEAR   = 2'd2;
  localparam logic [1:0] WR_CTRL = 2'd3;

  logic [1:0]  state;
  logic        run;
  logic        clr_pend;
  logic        col_pend;
  logic [31:0] col_q;
  logic [9:0]  clr_cnt;
  logic [11:0] idx;
  logic [4:0]  y_inc;
  logic        idle;
  logic        done;
  logic        take_clr;
  logic        take_col;
  logic        take_chr;

  // Cell index and the various handshake/priority decisions.
  always_comb begin
    idx      = {7'd0, CURSOR_Y} * 12'd80 + {5'd0, CURSOR_X};
    y_inc    = (CURSOR_Y == 5'd29) ? 5'd0 : CURSOR_Y + 5'd1;
    idle     = run & (state == IDLE);
    done     = M_WRITE & ~M_WAITREQUEST;
    take_clr = idle & (CLEAR_REQ | clr_pend);
    take_col = idle & ~take_clr & (COLOR_WE | col_pend);
    CHAR_READY = idle & ~CLEAR_REQ & ~clr_pend
               & ~COLOR_WE & ~col_pend;
    take_chr = CHAR_READY & CHAR_VALID;
    BUSY     = (state != IDLE);
  end

  // Writer FSM, event latches, cursor and registered bus outputs.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state       <= IDLE;
      run         <= 1'b0;
      clr_pend    <= 1'b0;
      col_pend    <= 1'b0;
      col_q       <= 32'd0;
      clr_cnt     <= 10'd0;
      CURSOR_X    <= 7'd0;
      CURSOR_Y    <= 5'd0;
      M_WRITE     <= 1'b0;
      M_ADDR      <= 12'd0;
      M_BYTE_EN   <= 4'd0;
      M_WRITEDATA <= 32'd0;
    end else begin
      run <= 1'b1;
      if (CLEAR_REQ) clr_pend <= 1'b1;
      if (COLOR_WE) begin
        col_pend <= 1'b1;
        col_q    <= COLOR_DATA;
      end
      unique case (state)
        IDLE: begin
          if (take_clr) begin
            clr_pend    <= 1'b0;
            state       <= CLEAR;
            clr_cnt     <= 10'd0;
            M_WRITE     <= 1'b1;
            M_ADDR      <= 12'd0;
            M_BYTE_EN   <= 4'hF;
            M_WRITEDATA <= 32'h2020_2020;
          end else if (take_col) begin
            col_pend    <= 1'b0;
            state       <= WR_CTRL;
            M_WRITE     <= 1'b1;
            M_ADDR      <= 12'd600;
            M_BYTE_EN   <= 4'hF;
            M_WRITEDATA <= COLOR_WE ? COLOR_DATA : col_q;
          end else if (take_chr) begin
            if (CHAR_DATA == 8'h0D) begin
              CURSOR_X <= 7'd0;
            end else if (CHAR_DATA == 8'h0A) begin
              CURSOR_X <= 7'd0;
              CURSOR_Y <= y_inc;
            end else begin
              state       <= WR_CHAR;
              M_WRITE     <= 1'b1;
              M_ADDR      <= {2'b00, idx[11:2]};
              M_BYTE_EN   <= 4'b0001 << idx[1:0];
              M_WRITEDATA <= {4{CHAR_DATA}};
            end
          end
        end
        WR_CHAR: begin
          if (done) begin
            M_WRITE <= 1'b0;
            state   <= IDLE;
            if (CURSOR_X == 7'd79) begin
              CURSOR_X <= 7'd0;
              CURSOR_Y <= y_inc;
            end else begin
              CURSOR_X <= CURSOR_X + 7'd1;
            end
          end
        end
        CLEAR: begin
          if (done) begin
            if (clr_cnt == 10'd599) begin
              M_WRITE  <= 1'b0;
              state    <= IDLE;
              CURSOR_X <= 7'd0;
              CURSOR_Y <= 5'd0;
            end else begin
              clr_cnt <= clr_cnt + 10'd1;
              M_ADDR  <= {2'b00, clr_cnt + 10'd1};
            end
          end
        end
        WR_CTRL: begin
          if (done) begin
            M_WRITE <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_text_console_writer.sv
// Directed bench for the VGA text console writer.
// Checks cursor, lane mapping, stalls, clear, colour and reset abort.
module tb_vga_text_console_writer;

  logic        CLK;
  logic        RESET;
  logic        CHAR_VALID;
  logic [7:0]  CHAR_DATA;
  logic        CHAR_READY;
  logic        CLEAR_REQ;
  logic        COLOR_WE;
  logic [31:0] COLOR_DATA;
  logic [11:0] M_ADDR;
  logic        M_WRITE;
  logic [3:0]  M_BYTE_EN;
  logic [31:0] M_WRITEDATA;
  logic        M_WAITREQUEST;
  logic [6:0]  CURSOR_X;
  logic [4:0]  CURSOR_Y;
  logic        BUSY;

  int tests = 0;
  int fails = 0;

  vga_text_console_writer dut (
    .CLK(CLK), .RESET(RESET),
    .CHAR_VALID(CHAR_VALID), .CHAR_DATA(CHAR_DATA),
    .CHAR_READY(CHAR_READY),
    .CLEAR_REQ(CLEAR_REQ), .COLOR_WE(COLOR_WE),
    .COLOR_DATA(COLOR_DATA),
    .M_ADDR(M_ADDR), .M_WRITE(M_WRITE),
    .M_BYTE_EN(M_BYTE_EN), .M_WRITEDATA(M_WRITEDATA),
    .M_WAITREQUEST(M_WAITREQUEST),
    .CURSOR_X(CURSOR_X), .CURSOR_Y(CURSOR_Y),
    .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_char(input logic [7:0] d);
    int n;
    n = 0;
    CHAR_DATA  = d;
    CHAR_VALID = 1'b1;
    while (!CHAR_READY && n < 20) begin
      tick();
      n++;
    end
    chk("ready_wait", {31'd0, CHAR_READY}, 32'd1);
    tick();
    CHAR_VALID = 1'b0;
    n = 0;
    while (BUSY && n < 20) begin
      tick();
      n++;
    end
    chk("idle_wait", {31'd0, BUSY}, 32'd0);
  endtask

  initial begin
    int done_n;
    int cyc;
    logic w;
    RESET         = 1'b0;
    CHAR_VALID    = 1'b0;
    CHAR_DATA     = 8'h00;
    CLEAR_REQ     = 1'b0;
    COLOR_WE      = 1'b0;
    COLOR_DATA    = 32'd0;
    M_WAITREQUEST = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_write", M_WRITE, 0);
    chk("rst_ready", CHAR_READY, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_x", CURSOR_X, 0);
    chk("rst_y", CURSOR_Y, 0);
    chk("rst_addr", M_ADDR, 0);
    RESET = 1'b1;
    tick();
    chk("rel_ready", CHAR_READY, 1);

    // 'A' at (0,0), no stall
    CHAR_DATA  = 8'h41;
    CHAR_VALID = 1'b1;
    tick();
    CHAR_VALID = 1'b0;
    chk("a_write", M_WRITE, 1);
    chk("a_addr", M_ADDR, 0);
    chk("a_be", M_BYTE_EN, 4'b0001);
    chk("a_data", M_WRITEDATA, 32'h4141_4141);
    chk("a_ready_lo", CHAR_READY, 0);
    chk("a_busy", BUSY, 1);
    tick();
    chk("a_done", M_WRITE, 0);
    chk("a_ready_hi", CHAR_READY, 1);
    chk("a_x", CURSOR_X, 1);

    // move to (5,2)
    send_char(8'h0A);
    send_char(8'h0A);
    chk("lf_x", CURSOR_X, 0);
    chk("lf_y", CURSOR_Y, 2);
    for (int i = 0; i < 5; i++) send_char(8'h30 + 8'(i));
    chk("c52_x", CURSOR_X, 5);
    chk("c52_y", CURSOR_Y, 2);

    // CR returns to column 0 without a write, then back to 5
    CHAR_DATA  = 8'h0D;
    CHAR_VALID = 1'b1;
    tick();
    CHAR_VALID = 1'b0;
    chk("cr_x", CURSOR_X, 0);
    chk("cr_nowrite", M_WRITE, 0);
    chk("cr_y", CURSOR_Y, 2);
    for (int i = 0; i < 5; i++) send_char(8'h61);

    // 0xC1 at index 165 with a 3-cycle stall
    CHAR_DATA     = 8'hC1;
    CHAR_VALID    = 1'b1;
    M_WAITREQUEST = 1'b1;
    tick();
    CHAR_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("st_write", M_WRITE, 1);
      chk("st_addr", M_ADDR, 41);
      chk("st_be", M_BYTE_EN, 4'b0010);
      chk("st_data", M_WRITEDATA, 32'hC1C1_C1C1);
      tick();
    end
    M_WAITREQUEST = 1'b0;
    chk("st4_write", M_WRITE, 1);
    chk("st4_addr", M_ADDR, 41);
    chk("st4_x", CURSOR_X, 5);
    tick();
    chk("st_done", M_WRITE, 0);
    chk("st_x", CURSOR_X, 6);

    // move to (79,29) and write 'Z'
    for (int i = 0; i < 27; i++) send_char(8'h0A);
    for (int i = 0; i < 79; i++) send_char(8'h2E);
    chk("e_x", CURSOR_X, 79);
    chk("e_y", CURSOR_Y, 29);
    CHAR_DATA  = 8'h5A;
    CHAR_VALID = 1'b1;
    tick();
    CHAR_VALID = 1'b0;
    chk("z_addr", M_ADDR, 599);
    chk("z_be", M_BYTE_EN, 4'b1000);
    chk("z_data", M_WRITEDATA, 32'h5A5A_5A5A);
    tick();
    chk("z_x", CURSOR_X, 0);
    chk("z_y", CURSOR_Y, 0);

    // LF at row 29 wraps to row 0
    for (int i = 0; i < 29; i++) send_char(8'h0A);
    chk("lf29_y", CURSOR_Y, 29);
    CHAR_DATA  = 8'h0A;
    CHAR_VALID = 1'b1;
    tick();
    CHAR_VALID = 1'b0;
    chk("lfw_nowrite", M_WRITE, 0);
    chk("lfw_x", CURSOR_X, 0);
    chk("lfw_y", CURSOR_Y, 0);

    // colour register write
    COLOR_DATA = 32'h01FE_0000;
    COLOR_WE   = 1'b1;
    tick();
    COLOR_WE = 1'b0;
    chk("col_write", M_WRITE, 1);
    chk("col_addr", M_ADDR, 600);
    chk("col_be", M_BYTE_EN, 4'hF);
    chk("col_data", M_WRITEDATA, 32'h01FE_0000);
    tick();
    chk("col_done", M_WRITE, 0);

    // clear with random stalls, two colour pulses mid-clear
    send_char(8'h42);
    chk("pre_clr_x", CURSOR_X, 1);
    CLEAR_REQ = 1'b1;
    tick();
    CLEAR_REQ = 1'b0;
    chk("clr_busy", BUSY, 1);
    done_n = 0;
    cyc    = 0;
    while (done_n < 600 && cyc < 5000) begin
      w = 1'($urandom_range(0, 1));
      M_WAITREQUEST = w;
      if (cyc == 40) begin
        COLOR_DATA = 32'h1111_2222;
        COLOR_WE   = 1'b1;
      end
      if (cyc == 400) begin
        COLOR_DATA = 32'h1234_5678;
        COLOR_WE   = 1'b1;
      end
      if (M_WRITE && !w) begin
        chk("clr_addr", M_ADDR, done_n);
        chk("clr_data", M_WRITEDATA, 32'h2020_2020);
        chk("clr_be", M_BYTE_EN, 4'hF);
        done_n++;
      end
      tick();
      COLOR_WE = 1'b0;
      cyc++;
    end
    M_WAITREQUEST = 1'b0;
    chk("clr_count", done_n, 600);
    chk("clr_x", CURSOR_X, 0);
    chk("clr_y", CURSOR_Y, 0);
    chk("clr_idle_write", M_WRITE, 0);
    chk("clr_pend_ready", CHAR_READY, 0);
    tick();
    chk("pc_write", M_WRITE, 1);
    chk("pc_addr", M_ADDR, 600);
    chk("pc_data", M_WRITEDATA, 32'h1234_5678);
    tick();
    chk("pc_done", M_WRITE, 0);
    tick();
    chk("pc_ready", CHAR_READY, 1);

    // reset during clear word 300
    send_char(8'h43);
    chk("pre_rst_x", CURSOR_X, 1);
    CLEAR_REQ = 1'b1;
    tick();
    CLEAR_REQ = 1'b0;
    repeat (300) tick();
    chk("r300_addr", M_ADDR, 300);
    chk("r300_write", M_WRITE, 1);
    M_WAITREQUEST = 1'b1;
    RESET = 1'b0;
    tick();
    chk("ra_write", M_WRITE, 0);
    chk("ra_x", CURSOR_X, 0);
    chk("ra_y", CURSOR_Y, 0);
    chk("ra_ready", CHAR_READY, 0);
    chk("ra_busy", BUSY, 0);
    RESET = 1'b1;
    M_WAITREQUEST = 1'b0;
    tick();
    chk("rb_ready", CHAR_READY, 1);
    tick();
    chk("rb_write", M_WRITE, 0);
    chk("rb_busy", BUSY, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_text_console_writer.md
VGA_TEXT_CONSOLE_WRITER -- requirements
Module: vga_text_console_writer

Interface
REQ-001 CLK  in  1  single system clock (50 MHz), all logic on rising edge.
REQ-002 RESET  in  1  synchronous, active-low reset; sampled on rising CLK.
REQ-003 CHAR_VALID  in  1  character stream valid.
REQ-004 CHAR_DATA  in  8  bit7 = inverse flag, bits 6:0 = code page 437 glyph code.
REQ-005 CHAR_READY  out  1  writer accepts CHAR_DATA this cycle.
REQ-006 CLEAR_REQ  in  1  one-cycle pulse; clear whole screen and home the cursor.
REQ-007 COLOR_WE  in  1  one-cycle pulse; write COLOR_DATA to the control register.
REQ-008 COLOR_DATA  in  32  control-register image: FGD_R/G/B at 24:13, BKG_R/G/B at 12:1.
REQ-009 M_ADDR  out  12  Avalon-MM master word address.
REQ-010 M_WRITE  out  1  Avalon-MM write request.
REQ-011 M_BYTE_EN  out  4  Avalon-MM byte enable.
REQ-012 M_WRITEDATA  out  32  Avalon-MM write data.
REQ-013 M_WAITREQUEST  in  1  slave stall; the transfer completes on a cycle with M_WRITE=1 and M_WAITREQUEST=0.
REQ-014 CURSOR_X  out  7  current column, 0-79.
REQ-015 CURSOR_Y  out  5  current row, 0-29.
REQ-016 BUSY  out  1  high in any state except IDLE.

Function
REQ-017 Screen is 80x30 cells: cell index = CURSOR_Y*80 + CURSOR_X (12 bits, 0-2399).
REQ-018 VRAM word address = index[11:2]; byte lane = index[1:0]; the control register is at word address 600 (0x258).
REQ-019 The writer SHALL implement states IDLE, WR_CHAR, CLEAR, WR_CTRL.
REQ-020 In IDLE, pending events SHALL be prioritized as CLEAR_REQ, then COLOR_WE, then CHAR_VALID; CLEAR_REQ and COLOR_WE pulses arriving outside IDLE SHALL be latched as one pending flag each and served on return to IDLE.
REQ-021 CHAR_READY SHALL be 1 only in IDLE with no pending clear or color event; a character is accepted when CHAR_VALID=1 and CHAR_READY=1.
REQ-022 Accepted 0x0D (CR): set CURSOR_X to 0; no bus write; stay in IDLE.
REQ-023 Accepted 0x0A (LF): set CURSOR_X to 0 and advance the row; no bus write; stay in IDLE.
REQ-024 Other accepted characters: enter WR_CHAR on the next edge.
  - WR_CHAR drives M_WRITE=1, M_ADDR=index[11:2], M_BYTE_EN=1<<lane, and M_WRITEDATA = CHAR_DATA replicated in all four bytes.
REQ-025 All master outputs SHALL hold stable while M_WAITREQUEST=1.
REQ-026 On transfer completion, advance the cursor and return to IDLE; latency with no stall is accept at cycle N, M_WRITE high at cycle N+1, CHAR_READY high again at cycle N+2.
REQ-027 Cursor advance: CURSOR_X+1; when CURSOR_X=79, set CURSOR_X to 0 and advance the row.
REQ-028 Row advance: CURSOR_Y+1; when CURSOR_Y=29, wrap CURSOR_Y to 0 (no scrolling).
REQ-029 CLEAR SHALL write 0x20202020 with M_BYTE_EN=1111 to word addresses 0..599 in ascending order, one transfer per completed handshake.
  - The word counter advances only on completion.
  - After word 599 completes, set the cursor to (0,0) and return to IDLE.
REQ-030 WR_CTRL SHALL write the COLOR_DATA value latched at the COLOR_WE pulse to address 600 with M_BYTE_EN=1111, then return to IDLE.
  - A later COLOR_WE before service SHALL overwrite the latched value.
REQ-031 M_WRITE SHALL be 0 in IDLE.
REQ-032 M_ADDR, M_BYTE_EN and M_WRITEDATA are don't-care whenever M_WRITE=0.
REQ-033 The writer SHALL never assert a read.

Reset
REQ-034 While RESET=0 at a rising edge, the next state SHALL be:
  - state IDLE; CURSOR_X=0, CURSOR_Y=0;
  - M_WRITE=0, M_ADDR=0, M_BYTE_EN=0, M_WRITEDATA=0;
  - CHAR_READY=0, BUSY=0;
  - pending flags, clear counter and latched color cleared.
REQ-035 Reset asserted mid-transfer, including during a stall, SHALL abort the transfer: M_WRITE is 0 after that edge and the partial clear is not resumed.
REQ-036 CHAR_READY SHALL rise on the first edge after RESET returns to 1.

Verification
REQ-037 Cursor (0,0), accept 'A' (0x41), no stall -> cycle N+1: M_ADDR=0, M_BYTE_EN=0001, M_WRITEDATA=0x41414141; then CURSOR_X=1.
REQ-038 Cursor (5,2) (index 165), 0xC1 with M_WAITREQUEST high for 3 cycles -> M_ADDR=41, M_BYTE_EN=0010, outputs stable for 4 cycles, then CURSOR_X=6.
REQ-039 Cursor (79,29), write 'Z' -> lane 3 at M_ADDR=599, cursor wraps to (0,0); LF at row 29 -> (0,0) with no bus write.
REQ-040 CLEAR_REQ with random waitrequest -> exactly 600 completed writes of 0x20202020 at addresses 0..599, then cursor (0,0); a COLOR_WE pulsed mid-clear is served next at address 600.
REQ-041 COLOR_WE with COLOR_DATA=0x01FE0000 -> one write at M_ADDR=600, M_BYTE_EN=1111, M_WRITEDATA=0x01FE0000.
REQ-042 RESET=0 during clear word 300 -> M_WRITE=0 next edge, cursor (0,0), CHAR_READY=1 the first edge after release.
